conv_pass_sequencer: RTL

CONV_PASS_SEQUENCER -- requirements
Module: conv_pass_sequencer

---
 rtl/conv_pkg.sv | 19 +
 rtl/seq_watchdog.sv | 29 ++
 rtl/conv_pass_sequencer.sv | 130 +++++++++++++
 3 files changed

// File: rtl/conv_pkg.sv
// Shared constants and FSM state encoding for the convolution pass sequencer.
// IDLE is encoded as zero so a reset state reads back as all-zero debug state.
package conv_pkg;

  localparam int IMG_AW = 10;
  localparam int W_AW   = 8;
  localparam int OUT_AW = 13;
  localparam int ACC_W  = 24;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LAUNCH = 3'd1,
    WAIT   = 3'd2,
    NEXT   = 3'd3,
    DONE   = 3'd4,
    ERR    = 3'd5
  } seq_state_t;

endpackage

// File: rtl/seq_watchdog.sv
// Engine watchdog: counts enabled cycles since the last clear.
// expired rises during the TIMEOUT-th enabled cycle.
module seq_watchdog #(
  parameter int TIMEOUT = 4096
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] count;

  assign expired = enable && (count == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/conv_pass_sequencer.sv
// Sequences NUM_PASSES convolution-engine passes per layer, rebasing weight and
// output addresses per pass and forwarding engine results to output memory.
//
// Handshake: start is a level sampled only in IDLE or ERR; eng_start is a
// one-cycle launch pulse; eng_done ends the pass on the cycle it is seen in
// WAIT; eng_valid is a strobe (no back-pressure) honoured only in WAIT.
module conv_pass_sequencer
  import conv_pkg::*;
#(
  parameter int NUM_PASSES = 4,
  parameter int W_STRIDE   = 9,
  parameter int OUT_STRIDE = 900,
  parameter int TIMEOUT    = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              layer_done,
  output logic              err,
  output logic              ovf,
  output logic              eng_start,
  input  logic              eng_done,
  input  logic              eng_valid,
  input  logic [ACC_W-1:0]  eng_data,
  input  logic [OUT_AW-1:0] eng_out_addr,
  output logic [W_AW-1:0]   w_base,
  output logic [2:0]        pass_idx,
  output logic              out_we,
  output logic [OUT_AW-1:0] out_addr,
  output logic [ACC_W-1:0]  out_data,
  output seq_state_t        dbg_state
);

  seq_state_t        state_q, state_d;
  logic              accept;
  logic              advance;
  logic              last_pass;
  logic              wd_expired;
  logic              addr_ok;
  logic [OUT_AW-1:0] out_base;

  assign last_pass = (pass_idx == 3'(NUM_PASSES - 1));
  // One extra bit so an OUT_STRIDE of 8192 still compares correctly.
  assign addr_ok   = ({1'b0, eng_out_addr} < 14'(OUT_STRIDE));

  seq_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clear   (state_q == LAUNCH),
    .enable  ((state_q == WAIT) && !eng_done),
    .expired (wd_expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    advance = 1'b0;
    case (state_q)
      IDLE, ERR: begin
        if (start) begin
          state_d = LAUNCH;
          accept  = 1'b1;
        end
      end
      LAUNCH: state_d = WAIT;
      WAIT: begin
        if (eng_done)        state_d = NEXT;
        else if (wd_expired) state_d = ERR;
      end
      NEXT: begin
        if (last_pass) begin
          state_d = DONE;
        end else begin
          state_d = LAUNCH;
          advance = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy       = (state_q == LAUNCH) || (state_q == WAIT) ||
                      (state_q == NEXT)   || (state_q == DONE);
  assign eng_start  = (state_q == LAUNCH);
  assign layer_done = (state_q == DONE);
  assign err        = (state_q == ERR);
  assign dbg_state  = state_q;

  // Pass bookkeeping and the registered result write port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pass_idx <= '0;
      w_base   <= '0;
      out_base <= '0;
      ovf      <= 1'b0;
      out_we   <= 1'b0;
      out_addr <= '0;
      out_data <= '0;
    end else begin
      out_we <= 1'b0;
      if (accept) begin
        pass_idx <= '0;
        w_base   <= '0;
        out_base <= '0;
        ovf      <= 1'b0;
      end else if (advance) begin
        pass_idx <= pass_idx + 3'd1;
        w_base   <= w_base + W_AW'(W_STRIDE);
        out_base <= out_base + OUT_AW'(OUT_STRIDE);
      end
      if ((state_q == WAIT) && eng_valid) begin
        if (addr_ok) begin
          out_we   <= 1'b1;
          out_addr <= out_base + eng_out_addr;
          out_data <= eng_data;
        end else begin
          ovf <= 1'b1;
        end
      end
    end
  end

endmodule
